// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcode selector values, iterative-unit
// state encoding and branch/jump immediate extraction.
package ex_pkg;

    localparam int OP_NOP   = 0;
    localparam int OP_ADDI  = 1;
    localparam int OP_ADD   = 2;
    localparam int OP_SUB   = 3;
    localparam int OP_BNE   = 4;
    localparam int OP_BEQ   = 5;
    localparam int OP_LUI   = 6;
    localparam int OP_JAL   = 7;
    localparam int OP_MUL   = 8;
    localparam int OP_MULHU = 9;
    localparam int OP_DIVU  = 10;
    localparam int OP_REMU  = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ex_state_t;

    // Raw (unextended) B-type immediate, bit 0 always zero.
    function automatic logic [12:0] imm_b(input logic [31:0] ins);
        return {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    // Raw (unextended) J-type immediate, bit 0 always zero.
    function automatic logic [20:0] imm_j(input logic [31:0] ins);
        return {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ex_iter_if.sv
// Link between the execute decode and the iterative multiply/divide unit.
// start is a one-cycle request honoured only while state is IDLE; done pulses for one cycle with lo/hi valid.
interface ex_iter_if #(parameter int XLEN = 32);
    logic             start;
    logic             is_div;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    ex_pkg::ex_state_t state;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  hi;

    modport master (output start, is_div, op_a, op_b, input state, busy, done, lo, hi);
    modport slave  (input start, is_div, op_a, op_b, output state, busy, done, lo, hi);
endinterface

// File: rtl/ex_iter_unit.sv
// Iterative unsigned multiplier / restoring divider retiring BPC bits per cycle.
// Results: multiply lo/hi = product halves, divide lo = quotient, hi = remainder.
module ex_iter_unit import ex_pkg::*; #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic clk,
    input  logic rst_n,
    ex_iter_if.slave bus
);

    localparam int N  = XLEN / BPC;
    localparam int CW = $clog2(N + 1);

    ex_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic            div_q;
    logic            div_zero;

    logic [XLEN+BPC-1:0] mul_sum;
    logic [XLEN:0]       div_r;
    logic [XLEN-1:0]     div_q_bits;

    assign div_zero = bus.is_div && (bus.op_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = div_zero ? ST_DONE : ST_BUSY;
            ST_BUSY: if (cnt_q == CW'(1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // One radix-2^BPC step of both algorithms; only the one matching div_q is committed.
    always_comb begin
        mul_sum = {{BPC{1'b0}}, hi_q} + ({{BPC{1'b0}}, b_q} * {{XLEN{1'b0}}, lo_q[BPC-1:0]});
        div_r      = {1'b0, hi_q};
        div_q_bits = lo_q;
        for (int i = 0; i < BPC; i++) begin
            div_r      = {div_r[XLEN-1:0], div_q_bits[XLEN-1]};
            div_q_bits = {div_q_bits[XLEN-2:0], 1'b0};
            if (div_r >= {1'b0, b_q}) begin
                div_r         = div_r - {1'b0, b_q};
                div_q_bits[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    div_q <= bus.is_div;
                    b_q   <= bus.op_b;
                    cnt_q <= CW'(N);
                    if (div_zero) begin
                        lo_q <= '1;
                        hi_q <= bus.op_a;
                    end else begin
                        lo_q <= bus.op_a;
                        hi_q <= '0;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (div_q) begin
                        hi_q <= div_r[XLEN-1:0];
                        lo_q <= div_q_bits;
                    end else begin
                        hi_q <= mul_sum[XLEN+BPC-1:BPC];
                        lo_q <= {mul_sum[BPC-1:0], lo_q[XLEN-1:BPC]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;
    assign bus.busy  = (state_q == ST_BUSY);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.lo    = lo_q;
    assign bus.hi    = hi_q;

endmodule

// File: rtl/ex_mc.sv
// Execute stage: zero-latency ALU/branch/jump decode plus a stalling iterative
// multiply/divide path; all outputs are combinational from inputs and state.
module ex_mc import ex_pkg::*; #(
    parameter int XLEN = 32,
    parameter int OH_W = 5,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     ins,
    input  logic [XLEN-1:0] ins_addr2ex,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd_addr2ex,
    input  logic            rd_wen,
    input  logic [OH_W-1:0] oh,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_wen2reg,
    output logic [XLEN-1:0] jump_addr2ctrl,
    output logic            jump_en2ctrl,
    output logic            hold2ctrl
);

    ex_iter_if #(.XLEN(XLEN)) iter_bus ();

    ex_iter_unit #(.XLEN(XLEN), .BPC(BPC)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (iter_bus.slave)
    );

    int              op;
    logic            is_multi;
    logic [4:0]      rd_q;
    logic            sel_hi_q;
    logic [XLEN-1:0] b_target, j_target, pc_plus4;
    logic            unused_ins;

    assign op         = int'(oh);
    assign is_multi   = (op >= OP_MUL) && (op <= OP_REMU);
    assign unused_ins = ^ins[6:0];

    assign iter_bus.start  = rst_n && (iter_bus.state == ST_IDLE) && is_multi;
    assign iter_bus.is_div = (op == OP_DIVU) || (op == OP_REMU);
    assign iter_bus.op_a   = op1;
    assign iter_bus.op_b   = op2;

    assign pc_plus4 = ins_addr2ex + XLEN'(4);
    assign b_target = ins_addr2ex + XLEN'($signed(imm_b(ins)));
    assign j_target = ins_addr2ex + XLEN'($signed(imm_j(ins)));

    // Destination and result half are latched at launch since inputs are ignored while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            sel_hi_q <= 1'b0;
        end else if (iter_bus.start) begin
            rd_q     <= rd_addr2ex;
            sel_hi_q <= (op == OP_MULHU) || (op == OP_REMU);
        end
    end

    always_comb begin
        rd_addr        = '0;
        rd_data        = '0;
        rd_wen2reg     = 1'b0;
        jump_addr2ctrl = '0;
        jump_en2ctrl   = 1'b0;
        hold2ctrl      = 1'b0;
        if (!rst_n) begin
            hold2ctrl = 1'b0;
        end else if (iter_bus.done) begin
            rd_wen2reg = 1'b1;
            rd_addr    = rd_q;
            rd_data    = sel_hi_q ? iter_bus.hi : iter_bus.lo;
        end else if (iter_bus.busy) begin
            hold2ctrl = 1'b1;
        end else begin
            case (op)
                OP_ADDI, OP_ADD: begin
                    rd_data    = op1 + op2;
                    rd_addr    = rd_addr2ex;
                    rd_wen2reg = rd_wen;
                end
                OP_SUB: begin
                    rd_data    = op1 - op2;
                    rd_addr    = rd_addr2ex;
                    rd_wen2reg = rd_wen;
                end
                OP_LUI: begin
                    rd_data    = XLEN'({ins[31:12], 12'b0});
                    rd_addr    = rd_addr2ex;
                    rd_wen2reg = rd_wen;
                end
                OP_JAL: begin
                    rd_data        = pc_plus4;
                    rd_addr        = rd_addr2ex;
                    rd_wen2reg     = rd_wen;
                    jump_addr2ctrl = j_target;
                    jump_en2ctrl   = 1'b1;
                end
                OP_BEQ: begin
                    jump_addr2ctrl = b_target;
                    jump_en2ctrl   = (op1 == op2);
                end
                OP_BNE: begin
                    jump_addr2ctrl = b_target;
                    jump_en2ctrl   = (op1 != op2);
                end
                OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: hold2ctrl = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
